mul_32: RTL

Multi-cycle 32×32 unsigned multiplier built from repeated shift-and-add, the inverse companion of the repeated-subtraction modulo unit in the arithmetic datapath. It takes two 32-bit operands on a start pulse and iterates one multiplier bit per clock. It returns a 64-bit product with a one-cycle done strobe. It sits beside the modulo unit behind the same start/done style of control and is driven by the datapath controller.

---
 rtl/mul_32_pkg.sv | 20 ++
 rtl/mul_32.sv | 113 +++++++++++
 2 files changed

// File: rtl/mul_32_pkg.sv
// Shared arithmetic package: default operand width, sequencer state encoding
// and counter sizing used by the multi-cycle multiply and modulo units.
package mul_32_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // One spare bit so the counter can represent WIDTH itself.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/mul_32.sv
// Multi-cycle unsigned shift-and-add multiplier: one multiplier bit per clock,
// 2*WIDTH-bit product presented with a one-cycle done strobe.
//
// state | meaning
// IDLE  | waiting for start; operands latched on an accepted start
// CALC  | WIDTH add/shift iterations, counter runs 0..WIDTH-1
// DONE  | accumulator copied to product, done strobed, back to IDLE
module mul_32
   import mul_32_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e            state_q, state_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     product_q, product_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         product_q <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      product_d = product_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, a};
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = CALC;
            end
         end
         CALC: begin
            busy_d = 1'b1;
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // busy stays up through the cycle in which done is visible
            busy_d    = 1'b1;
            done_d    = 1'b1;
            product_d = acc_q;
            state_d   = IDLE;
         end
         default: begin
            state_d   = IDLE;
            mcand_d   = '0;
            acc_d     = '0;
            product_d = '0;
            mplier_d  = '0;
            cnt_d     = '0;
         end
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule
